instr_encoder_loader: RTL and testbench
=======================================

# instr_encoder_loader

Sequential RISC-V RV32I instruction encoder and instruction-memory loader. It accepts instruction fields (format, opcode, registers, func3/func7, byte-offset immediate) over a valid/ready handshake. It packs each field set into a 32-bit instruction word and writes the words to consecutive instruction-memory addresses. It sits between the test/boot program source and the instruction memory, and is the inverse of the core's field decoder.

## Interface
- ADDR_W, 10: instruction-memory word-address width.
- MAX_WORDS, 1024: words accepted per load session; must be ≤ 2^ADDR_W.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a session (ignored unless IDLE).
- base_addr  in  ADDR_W  first write word-address, latched on start.
- in_valid  in  1  field set valid.
- in_ready  out  1  encoder can accept.
- in_last  in  1  final word of session, qualified by in_valid.
- fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal.
- opcode  in  7  instruction[6:0].
- rd, rs1, rs2  in  5 each  register indices.
- func3  in  3;  func7  in  7.
- imm  in  32  signed byte-offset immediate (U: full upper value).
- imem_we  out  1  write strobe.
- imem_addr  out  ADDR_W  write word-address.
- imem_wdata  out  32  encoded instruction.
- busy  out  1  session active.
- done  out  1  one-cycle pulse at end of session.
- word_count  out  ADDR_W+1  words written this session.
- err_fmt  out  1  sticky: illegal fmt seen.
- err_imm  out  1  sticky: immediate out of range (only with the range-check feature compiled in; otherwise tied 0).

## Operation
- States: IDLE → LOAD → FLUSH → DONE → IDLE.
- IDLE: in_ready=0. On start: latch base_addr into the write pointer, clear word_count, err_fmt and err_imm, and go to LOAD.
- LOAD: in_ready=1. A handshake (in_valid&in_ready) registers the encoded word into the output stage.
- A handshake with in_last=1, or the handshake that brings the accepted count to MAX_WORDS, moves LOAD → FLUSH.
- FLUSH: in_ready=0. Lasts one cycle while the last write retires, then goes to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Field packing: opcode→[6:0]. rd→[11:7] for R/I/U/J. func3→[14:12] for R/I/S/B. rs1→[19:15] for R/I/S/B. rs2→[24:20] for R/S/B. func7→[31:25] for R only.
- Immediate packing:
  - I: imm[11:0]→[31:20].
  - S: imm[11:5]→[31:25]; imm[4:0]→[11:7].
  - B: imm[12]→[31]; imm[10:5]→[30:25]; imm[4:1]→[11:8]; imm[11]→[7].
  - U: imm[31:12]→[31:12].
  - J: imm[20]→[31]; imm[10:1]→[30:21]; imm[11]→[20]; imm[19:12]→[19:12].
- Illegal fmt: the word is written as 0x00000013 (NOP) and err_fmt is set.
- Write pointer increments modulo 2^ADDR_W after each write; wrap-around is legal.
- start while not IDLE is ignored.
- reset at any point, including mid-session: immediate return to IDLE. The pending write is dropped (imem_we=0 next cycle).

## Timing
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, word_count=0, err_fmt=0, err_imm=0.
- Latency: handshake in cycle N → imem_we=1 with addr/wdata in cycle N+1. imem_we is high for exactly one cycle per accepted word.
- Throughput: one word per cycle in LOAD.
- word_count increments in the same cycle imem_we is asserted.
- in_ready rises the cycle after start is accepted.
- busy=1 in LOAD and FLUSH.
- done occurs 2 cycles after the final handshake.

## Configuration
- ENC_RANGE_CHECK_EN defined: err_imm is set when the immediate is out of range. Out-of-range means:
  - I/S outside −2048..2047.
  - B outside −4096..4094, or imm[0]=1.
  - J outside −1048576..1048574, or imm[0]=1.
  - U with imm[11:0]≠0.
- The offending word is still written, truncated per the packing rules.
- Undefined: the checker logic is absent, err_imm is tied 0, and packing is unchanged.

## Structure
- Shared package riscv_pkg: fmt enum (FMT_R..FMT_J), NOP constant 32'h0000_0013, opcode constants.
- One sub-module, instr_field_packer: purely combinational fields→32-bit word plus range-check flags. The parent holds the FSM, pointer, counter and output register.

## Test plan
- R add x3,x1,x2 (opcode 0x33, f3=0, f7=0), base_addr=0x010 → one write at 0x010, data 0x002081B3, then done.
- I addi x1,x0,5, then S sw x2,8(x1) with in_last on the second → writes 0x00500093 then 0x0020A423 on consecutive cycles, word_count=2.
- B beq x0,x0,−4 and J jal x1,8 → 0xFE000EE3, 0x008000EF.
- MAX_WORDS=4 without in_last, continuous valid → exactly 4 writes, in_ready falls after the 4th handshake, done pulses. base_addr=2^ADDR_W−2 wraps the address to 0.
- fmt=7 → NOP written and err_fmt=1. With ENC_RANGE_CHECK_EN, I-type imm=2048 sets err_imm=1.
- reset asserted the cycle after a handshake → no imem_we next cycle, all outputs at reset values.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I encoding types and constants used by the
// instruction encoder/loader and its field packer.
package riscv_pkg;

  // Instruction formats as presented on the fmt input; codes 6 and 7 are illegal.
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // Load-session sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_DONE
  } load_state_e;

  // addi x0,x0,0 -- written in place of any word whose format is illegal.
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // Base opcodes of RV32I.
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

endpackage

// File: rtl/instr_field_packer.sv
// instr_field_packer: purely combinational RV32I field packer. Turns one set of
// instruction fields into a 32-bit word, flags an illegal format and, when
// ENC_RANGE_CHECK_EN is defined, flags an immediate the format cannot represent.
module instr_field_packer
  import riscv_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  func3_i,
  input  logic [6:0]  func7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        fmtIllegal_o
`ifdef ENC_RANGE_CHECK_EN
  ,
  output logic        immBad_o
`endif
);

  // Scatter the fields into their bit positions; unknown formats become a NOP.
  always_comb begin
    word_o       = NOP_WORD;
    fmtIllegal_o = 1'b0;
    case (fmt_i)
      FMT_R: word_o = {func7_i, rs2_i, rs1_i, func3_i, rd_i, opcode_i};
      FMT_I: word_o = {imm_i[11:0], rs1_i, func3_i, rd_i, opcode_i};
      FMT_S: word_o = {imm_i[11:5], rs2_i, rs1_i, func3_i, imm_i[4:0], opcode_i};
      FMT_B: word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, func3_i,
                       imm_i[4:1], imm_i[11], opcode_i};
      FMT_U: word_o = {imm_i[31:12], rd_i, opcode_i};
      FMT_J: word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                       rd_i, opcode_i};
      default: begin
        word_o       = NOP_WORD;
        fmtIllegal_o = 1'b1;
      end
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  logic signed [31:0] immSigned;
  assign immSigned = $signed(imm_i);

  // Flag immediates that would lose bits or alignment when packed.
  always_comb begin
    immBad_o = 1'b0;
    case (fmt_i)
      FMT_I, FMT_S: immBad_o = (immSigned < -32'sd2048) || (immSigned > 32'sd2047);
      FMT_B:        immBad_o = (immSigned < -32'sd4096) || (immSigned > 32'sd4094)
                               || imm_i[0];
      FMT_J:        immBad_o = (immSigned < -32'sd1048576) || (immSigned > 32'sd1048574)
                               || imm_i[0];
      FMT_U:        immBad_o = (imm_i[11:0] != 12'd0);
      default:      immBad_o = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: accepts RV32I field sets over a valid/ready handshake,
// encodes each into a 32-bit word and writes the words to consecutive
// instruction-memory addresses. Optional immediate range checking is compiled
// in with the ENC_RANGE_CHECK_EN macro; without it err_imm is tied low.
module instr_encoder_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        func3,
  input  logic [6:0]        func7,
  input  logic [31:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_fmt,
  output logic              err_imm
);

  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W+1)'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  load_state_e       state_q, state_d;
  logic [ADDR_W-1:0] writePtr_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [31:0]       memData_q;
  logic              memWe_q;
  logic [ADDR_W:0]   wordCount_q;
  logic              errFmt_q;

  logic [31:0]       packedWord;
  logic              fmtIllegal;
  logic              handshake;
  logic              sessionStart;
  logic              finalWord;

`ifdef ENC_RANGE_CHECK_EN
  logic              immBad;
  logic              errImm_q;
`endif

  instr_field_packer u_packer (
    .fmt_i        (fmt),
    .opcode_i     (opcode),
    .rd_i         (rd),
    .rs1_i        (rs1),
    .rs2_i        (rs2),
    .func3_i      (func3),
    .func7_i      (func7),
    .imm_i        (imm),
    .word_o       (packedWord),
    .fmtIllegal_o (fmtIllegal)
`ifdef ENC_RANGE_CHECK_EN
    ,
    .immBad_o     (immBad)
`endif
  );

  assign in_ready     = (state_q == ST_LOAD);
  assign handshake    = in_valid & in_ready;
  assign sessionStart = (state_q == ST_IDLE) & start;
  // The session ends on an explicit last word or when this word fills the quota.
  assign finalWord    = in_last | ((wordCount_q + CNT_ONE) == CNT_MAX);

  // Session state register; reset abandons any session in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Session sequencing: wait for start, load words, let the last write retire, pulse done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD:  if (handshake && finalWord) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output write stage, write pointer, counter and sticky format error.
  always_ff @(posedge clk) begin
    if (reset) begin
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memData_q   <= '0;
      writePtr_q  <= '0;
      wordCount_q <= '0;
      errFmt_q    <= 1'b0;
    end else begin
      memWe_q <= handshake;
      if (sessionStart) begin
        writePtr_q  <= base_addr;
        wordCount_q <= '0;
        errFmt_q    <= 1'b0;
      end
      if (handshake) begin
        memAddr_q   <= writePtr_q;
        memData_q   <= packedWord;
        writePtr_q  <= writePtr_q + PTR_ONE;
        wordCount_q <= wordCount_q + CNT_ONE;
        if (fmtIllegal) errFmt_q <= 1'b1;
      end
    end
  end

`ifdef ENC_RANGE_CHECK_EN
  // Sticky immediate range error, cleared when a new session starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      errImm_q <= 1'b0;
    end else if (sessionStart) begin
      errImm_q <= 1'b0;
    end else if (handshake && immBad) begin
      errImm_q <= 1'b1;
    end
  end

  assign err_imm = errImm_q;
`else
  assign err_imm = 1'b0;
`endif

  assign imem_we    = memWe_q;
  assign imem_addr  = memAddr_q;
  assign imem_wdata = memData_q;
  assign word_count = wordCount_q;
  assign err_fmt    = errFmt_q;
  assign busy       = (state_q == ST_LOAD) | (state_q == ST_FLUSH);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed and randomized load sessions checked against
// a behavioural encoding model and a write scoreboard.
module tb_instr_encoder_loader;

  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 4;

  logic              clk = 1'b0;
  logic              reset, start, in_valid, in_last;
  logic [ADDR_W-1:0] base_addr;
  logic              in_ready;
  logic [2:0]        fmt;
  logic [6:0]        opcode, func7;
  logic [4:0]        rd, rs1, rs2;
  logic [2:0]        func3;
  logic [31:0]       imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy, done, err_fmt, err_imm;
  logic [ADDR_W:0]   word_count;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .func3(func3), .func7(func7), .imm(imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .word_count(word_count),
    .err_fmt(err_fmt), .err_imm(err_imm)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] expWord;
  } itemT;

  itemT              stimQ[$];
  logic [ADDR_W-1:0] expAddrQ[$];
  logic [31:0]       expDataQ[$];
  int                checks = 0;
  int                failures = 0;
  int                writesSeen = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Encoding model: each field is shifted to its slot with plain arithmetic.
  function automatic logic [31:0] refEncode(input itemT it);
    logic [31:0] i, w, regs;
    i = it.imm;
    w = 32'(it.opc);
    regs = (32'(it.f3) << 12) + (32'(it.rs1) << 15);
    case (it.fmt)
      3'd0: w = w + (32'(it.rd) << 7) + regs + (32'(it.rs2) << 20) + (32'(it.f7) << 25);
      3'd1: w = w + (32'(it.rd) << 7) + regs + ((i & 32'hFFF) << 20);
      3'd2: w = w + ((i & 32'h1F) << 7) + regs + (32'(it.rs2) << 20)
                  + (((i >> 5) & 32'h7F) << 25);
      3'd3: w = w + (((i >> 11) & 32'h1) << 7) + (((i >> 1) & 32'hF) << 8) + regs
                  + (32'(it.rs2) << 20) + (((i >> 5) & 32'h3F) << 25)
                  + (((i >> 12) & 32'h1) << 31);
      3'd4: w = w + (32'(it.rd) << 7) + (i & 32'hFFFF_F000);
      3'd5: w = w + (32'(it.rd) << 7) + (i & 32'h000F_F000) + (((i >> 11) & 32'h1) << 20)
                  + (((i >> 1) & 32'h3FF) << 21) + (((i >> 20) & 32'h1) << 31);
      default: w = 32'h0000_0013;
    endcase
    return w;
  endfunction

  function automatic bit refImmBad(input itemT it);
    longint s;
    s = longint'($signed(it.imm));
    case (it.fmt)
      3'd1, 3'd2: return (s < -2048) || (s > 2047);
      3'd3:       return (s < -4096) || (s > 4094) || it.imm[0];
      3'd4:       return it.imm[11:0] != 12'd0;
      3'd5:       return (s < -1048576) || (s > 1048574) || it.imm[0];
      default:    return 1'b0;
    endcase
  endfunction

  function automatic itemT mkItem(input logic [2:0] f, input logic [6:0] o, input logic [4:0] d,
                                  input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic [31:0] im, input logic [31:0] exp);
    itemT it;
    it.fmt = f; it.opc = o; it.rd = d; it.rs1 = s1; it.rs2 = s2;
    it.f3 = f3; it.f7 = f7; it.imm = im; it.expWord = exp;
    return it;
  endfunction

  function automatic itemT randItem();
    itemT it;
    it.fmt = ($urandom_range(0, 9) == 9) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
    it.opc = 7'($urandom); it.rd = 5'($urandom); it.rs1 = 5'($urandom); it.rs2 = 5'($urandom);
    it.f3 = 3'($urandom); it.f7 = 7'($urandom);
    case ($urandom_range(0, 2))
      0:       it.imm = $urandom;
      1:       it.imm = 32'($urandom_range(0, 8400)) - 32'd4200;
      default: it.imm = $urandom & 32'hFFFF_F000;
    endcase
    it.expWord = refEncode(it);
    return it;
  endfunction

  // Write scoreboard: every imem write must match the next expected address/data.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (expAddrQ.size() == 0) begin
        checkOutput("unexpected_write", imem_we, 0);
      end else begin
        writesSeen++;
        checkOutput("wr_addr", imem_addr, expAddrQ.pop_front());
        checkOutput("wr_data", imem_wdata, expDataQ.pop_front());
        checkOutput("wr_count", word_count, writesSeen);
      end
    end
  end

  task automatic driveItem(input itemT it);
    fmt = it.fmt; opcode = it.opc; rd = it.rd; rs1 = it.rs1; rs2 = it.rs2;
    func3 = it.f3; func7 = it.f7; imm = it.imm;
  endtask

  // Runs one session over the items in stimQ, then checks flush/done/error flags.
  task automatic applyStimulus(input logic [ADDR_W-1:0] base, input bit useLast,
                               input bit gaps, input bit pokeStart);
    int n, sent, guard;
    bit expFmt, expImm;
    logic [ADDR_W-1:0] ptr;
    n = stimQ.size(); sent = 0; guard = 0; expFmt = 0; expImm = 0; ptr = base;
    @(negedge clk);
    start = 1'b1; base_addr = base; writesSeen = 0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("ready_after_start", in_ready, 1);
    while (sent < n && guard < 200) begin
      guard++;
      checkOutput("ready_in_load", in_ready, 1);
      start = pokeStart && ($urandom_range(0, 3) == 0);
      base_addr = ADDR_W'($urandom);
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0; in_last = 1'b0;
      end else begin
        driveItem(stimQ[sent]);
        in_valid = 1'b1;
        in_last = useLast && (sent == n - 1);
      end
      if (in_valid && in_ready) begin
        expAddrQ.push_back(ptr);
        expDataQ.push_back(stimQ[sent].expWord);
        expFmt |= (stimQ[sent].fmt >= 3'd6);
        expImm |= refImmBad(stimQ[sent]);
        ptr = ptr + ADDR_W'(1);
        sent++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
    if (guard >= 200) checkOutput("session_timeout", sent, n);
    checkOutput("flush_ready", in_ready, 0);
    checkOutput("flush_busy", busy, 1);
    checkOutput("flush_done", done, 0);
    @(negedge clk);
    checkOutput("done_pulse", done, 1);
    checkOutput("done_busy", busy, 0);
    checkOutput("done_count", word_count, n);
    checkOutput("done_err_fmt", err_fmt, expFmt);
`ifdef ENC_RANGE_CHECK_EN
    checkOutput("done_err_imm", err_imm, expImm);
`else
    checkOutput("done_err_imm", err_imm, 0);
`endif
    checkOutput("writes_pending", expAddrQ.size(), 0);
    @(negedge clk);
    checkOutput("done_cleared", done, 0);
    stimQ.delete();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready"}, in_ready, 0);
    checkOutput({tag, "_we"}, imem_we, 0);
    checkOutput({tag, "_addr"}, imem_addr, 0);
    checkOutput({tag, "_wdata"}, imem_wdata, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_count"}, word_count, 0);
    checkOutput({tag, "_err_fmt"}, err_fmt, 0);
    checkOutput({tag, "_err_imm"}, err_imm, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; base_addr = '0;
    fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; func3 = '0; func7 = '0; imm = '0;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    reset = 1'b0;

    // add x3,x1,x2 at 0x010
    stimQ.push_back(mkItem(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF, 32'h0020_81B3));
    applyStimulus(10'h010, 1'b1, 1'b0, 1'b0);

    // addi x1,x0,5 then sw x2,8(x1), back to back
    stimQ.push_back(mkItem(3'd1, 7'h13, 5'd1, 5'd0, 5'd31, 3'd0, 7'h7F, 32'd5, 32'h0050_0093));
    stimQ.push_back(mkItem(3'd2, 7'h23, 5'd31, 5'd1, 5'd2, 3'd2, 7'h7F, 32'd8, 32'h0020_A423));
    applyStimulus(10'h100, 1'b1, 1'b0, 1'b0);

    // beq x0,x0,-4 and jal x1,8
    stimQ.push_back(mkItem(3'd3, 7'h63, 5'd31, 5'd0, 5'd0, 3'd0, 7'h7F, 32'hFFFF_FFFC, 32'hFE00_0EE3));
    stimQ.push_back(mkItem(3'd5, 7'h6F, 5'd1, 5'd31, 5'd31, 3'd7, 7'h7F, 32'd8, 32'h0080_00EF));
    applyStimulus(10'h200, 1'b1, 1'b0, 1'b0);

    // MAX_WORDS without in_last, starting two words below the top of memory
    for (int k = 0; k < MAX_WORDS; k++) stimQ.push_back(randItem());
    applyStimulus(10'h3FE, 1'b0, 1'b0, 1'b0);

    // illegal format becomes a NOP; I-type immediate 2048 is out of range
    stimQ.push_back(mkItem(3'd7, 7'h33, 5'd5, 5'd6, 5'd7, 3'd1, 7'h20, 32'd0, 32'h0000_0013));
    begin
      itemT it;
      it = mkItem(3'd1, 7'h13, 5'd4, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048, 32'd0);
      it.expWord = refEncode(it);
      stimQ.push_back(it);
    end
    applyStimulus(10'h020, 1'b1, 1'b0, 1'b0);

    // randomized sessions with gaps and ignored start pulses
    for (int s = 0; s < 24; s++) begin
      int n;
      bit useLast;
      n = $urandom_range(1, MAX_WORDS);
      for (int k = 0; k < n; k++) stimQ.push_back(randItem());
      useLast = (n < MAX_WORDS) ? 1'b1 : 1'($urandom_range(0, 1));
      applyStimulus(ADDR_W'($urandom), useLast, 1'b1, 1'b1);
    end

    // reset the cycle after a handshake: the following write must be dropped
    begin
      itemT a, b;
      a = mkItem(3'd0, 7'h33, 5'd9, 5'd10, 5'd11, 3'd4, 7'h20, 32'd0, 32'd0);
      a.expWord = refEncode(a);
      b = randItem();
      @(negedge clk);
      start = 1'b1; base_addr = 10'h155; writesSeen = 0;
      @(negedge clk);
      start = 1'b0;
      driveItem(a); in_valid = 1'b1; in_last = 1'b0;
      expAddrQ.push_back(10'h155); expDataQ.push_back(a.expWord);
      @(negedge clk);
      reset = 1'b1;
      driveItem(b);
      @(negedge clk);
      checkResetState("midreset");
      reset = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      checkOutput("post_reset_busy", busy, 0);
      checkOutput("post_reset_pending", expAddrQ.size(), 0);
    end

    // recovery session after the mid-session reset
    for (int k = 0; k < 3; k++) stimQ.push_back(randItem());
    applyStimulus(10'h3FF, 1'b1, 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
